// File: rtl/axi_ram_pkg.sv
// axi_ram_pkg: shared FSM state encoding and AXI response codes for the AXI RAM slave.
package axi_ram_pkg;
    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: single-outstanding AXI4 INCR slave bridging to a 1-cycle-latency single-port RAM.
module axi_ram_slave
    import axi_ram_pkg::*;
#(
    parameter int RAM_AW = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    state_t state, state_nx;
    logic [RAM_AW-1:0] addr;
    logic [7:0] len, beat;
    logic [31:0] rdata_q;
    logic last_rd, fresh, err, err_nx;
    logic grant_w, grant_r, last_beat, w_hs, r_hs;
    logic unused_addr;

    assign unused_addr = ^{araddr, awaddr};
    assign last_beat = beat == len;
    // Round-robin between channels; last_rd resets high so a write wins first.
    assign grant_w = awvalid && (!arvalid || last_rd);
    assign grant_r = arvalid && !grant_w;
    assign w_hs = state == WR_DATA && wvalid;
    assign r_hs = state == RD_DATA && rready;
    assign err_nx = err | (wlast != last_beat);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant_w ? WR_DATA : grant_r ? RD_REQ : IDLE;
            RD_REQ:  state_nx = RD_DATA;
            RD_DATA: state_nx = rready ? (last_beat ? IDLE : RD_REQ) : RD_DATA;
            WR_DATA: state_nx = (wvalid && last_beat) ? WR_RESP : WR_DATA;
            WR_RESP: state_nx = bready ? IDLE : WR_RESP;
            default: state_nx = IDLE;
        endcase
    end

    // RAM data arrives in the first RD_DATA cycle; rdata_q holds it through stalls.
    always_comb begin
        arready   = state == IDLE && grant_r;
        awready   = state == IDLE && grant_w;
        rvalid    = state == RD_DATA;
        rlast     = rvalid && last_beat;
        rresp     = RESP_OKAY;
        rdata     = fresh ? ram_rdata : rdata_q;
        wready    = state == WR_DATA;
        bvalid    = state == WR_RESP;
        ram_en    = state == RD_REQ || w_hs;
        ram_wen   = w_hs ? wstrb : 4'b0000;
        ram_addr  = addr;
        ram_wdata = wdata;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr    <= '0;
            len     <= '0;
            beat    <= '0;
            rid     <= '0;
            bid     <= '0;
            bresp   <= RESP_OKAY;
            err     <= 1'b0;
            fresh   <= 1'b0;
            rdata_q <= '0;
            last_rd <= 1'b1;
        end else begin
            fresh <= state == RD_REQ;
            if (fresh) rdata_q <= ram_rdata;
            if (arready) begin
                addr    <= araddr[RAM_AW+1:2];
                len     <= arlen;
                beat    <= '0;
                rid     <= arid;
                last_rd <= 1'b1;
            end
            if (awready) begin
                addr    <= awaddr[RAM_AW+1:2];
                len     <= awlen;
                beat    <= '0;
                bid     <= awid;
                err     <= 1'b0;
                last_rd <= 1'b0;
            end
            if (r_hs || w_hs) begin
                addr <= addr + RAM_AW'(1);
                beat <= beat + 8'd1;
            end
            if (w_hs) begin
                err <= err_nx;
                if (last_beat) bresp <= err_nx ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end
endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter RAM_AW, default 16, the RAM word-address width (RAM size is 4*2^RAM_AW bytes).
REQ-002 SHALL have port aclk  in  1  the single clock.
REQ-003 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port arid  in  4  read ID.
REQ-005 SHALL have port araddr  in  32  read byte address.
REQ-006 SHALL have port arlen  in  8  read beats minus one.
REQ-007 SHALL have ports arvalid  in  1 and arready  out  1, forming the AR handshake.
REQ-008 SHALL have port rid  out  4  echo of the captured arid.
REQ-009 SHALL have port rdata  out  32  read data.
REQ-010 SHALL have port rresp  out  2  read response, always 2'b00.
REQ-011 SHALL have port rlast  out  1  final read beat.
REQ-012 SHALL have ports rvalid  out  1 and rready  in  1, forming the R handshake.
REQ-013 SHALL have port awid  in  4  write ID.
REQ-014 SHALL have port awaddr  in  32  write byte address.
REQ-015 SHALL have port awlen  in  8  write beats minus one.
REQ-016 SHALL have ports awvalid  in  1 and awready  out  1, forming the AW handshake.
REQ-017 SHALL have port wdata  in  32  write data.
REQ-018 SHALL have port wstrb  in  4  byte strobes.
REQ-019 SHALL have port wlast  in  1  final write beat flag from the master.
REQ-020 SHALL have ports wvalid  in  1 and wready  out  1, forming the W handshake.
REQ-021 SHALL have port bid  out  4  echo of the captured awid.
REQ-022 SHALL have port bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-023 SHALL have ports bvalid  out  1 and bready  in  1, forming the B handshake.
REQ-024 SHALL have port ram_en  out  1  RAM access enable.
REQ-025 SHALL have port ram_wen  out  4  RAM byte write enables; 0 means read.
REQ-026 SHALL have port ram_addr  out  RAM_AW  RAM word address.
REQ-027 SHALL have port ram_wdata  out  32  RAM write data.
REQ-028 SHALL have port ram_rdata  in  32  RAM read data, valid 1 cycle after a read.

Function
REQ-029 SHALL implement FSM IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP, with exactly one transaction in flight.
REQ-030 SHALL drive arready/awready only in IDLE (combinational grant); if both arvalid and awvalid are high, the channel not served last wins, with write first after reset.
REQ-031 SHALL, on a handshake, capture id, addr[RAM_AW+1:2] and len, clear the beat counter, and go IDLE->RD_REQ on AR or IDLE->WR_DATA on AW; address bits above RAM_AW+1 and [1:0] are ignored, and all bursts are INCR with 4-byte beats.
REQ-032 SHALL, in RD_REQ, pulse ram_en=1, ram_wen=0 for one cycle, then enter RD_DATA and register ram_rdata into rdata with rvalid=1; an AR handshake in cycle N gives rvalid in cycle N+2.
REQ-033 SHALL hold rdata, rid, rlast and rvalid stable until rready; on handshake, go RD_DATA->RD_REQ with addr+1 (modulo 2^RAM_AW, wrap allowed), or RD_DATA->IDLE if beat==len; rlast=(beat==len).
REQ-034 SHALL drive wready=1 in WR_DATA; each W handshake drives ram_en=1, ram_wen=wstrb, ram_wdata=wdata, ram_addr=addr in that same cycle, then increments addr and beat.
REQ-035 SHALL go WR_DATA->WR_RESP on the beat where beat==len; bresp=2'b10 if wlast mismatched beat==len on any beat, else 2'b00; an early wlast does not end the burst.
REQ-036 SHALL hold bvalid=1 with bid/bresp in WR_RESP until bready, then go to IDLE; a new request is accepted no earlier than the next cycle.
REQ-037 SHALL keep ram_en=0 in every cycle not named in REQ-032/034; wstrb=0 still counts as a beat.

Reset
REQ-038 SHALL, on aresetn low (at any time, including mid-burst), force IDLE, rvalid=bvalid=wready=ram_en=0, ram_wen=0, rdata/rid/bid/bresp=0, last-served=read; an in-flight transaction is dropped.

Structure
REQ-039 SHALL take the FSM state enum and the constants RESP_OKAY/RESP_SLVERR from shared package axi_ram_pkg.
REQ-040 SHALL be a single module with no sub-module; the bench SHALL supply a behavioural single-port RAM model, sram_sp_1clk.

Verification
REQ-041 SHALL check a single write (awaddr=0x10, awlen=0, wdata=0xA5A5_0000, wstrb=4'b0011, wlast=1) -> ram_addr=4, ram_wen=0011, bvalid with bresp=00, bid=awid.
REQ-042 SHALL check a 4-beat read from 0x100 with rready toggling every cycle -> rdata holds while stalled, rlast only on beat 3, rid=arid.
REQ-043 SHALL check simultaneous arvalid and awvalid after reset -> write granted first, read next; alternation repeats.
REQ-044 SHALL check awlen=1 with wlast=1 on beat 0 -> 2 RAM writes occur, then bresp=2'b10.
REQ-045 SHALL check a read burst at word 2^RAM_AW-1 with arlen=1 -> second ram_addr=0.
REQ-046 SHALL check aresetn asserted during RD_DATA -> rvalid=0 immediately and the next AR is accepted after release.
